// File: rtl/aha_axi_burst_master.sv
// AXI4 burst manager: turns one (addr, len, rd/wr) command into a single INCR burst
// on 64-bit AXI, streaming write data in and read data out, one transaction at a time.
module aha_axi_burst_master #(
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID   = 0,
    parameter int ARB_PRIO = 0
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    // command
    input  logic                CMD_VALID,
    output logic                CMD_READY,
    input  logic                CMD_WRITE,
    input  logic [31:0]         CMD_ADDR,
    input  logic [7:0]          CMD_LEN,
    // write beat stream
    input  logic [63:0]         WR_DATA,
    input  logic [7:0]          WR_STRB,
    input  logic                WR_VALID,
    output logic                WR_READY,
    // read beat stream
    output logic [63:0]         RD_DATA,
    output logic                RD_LAST,
    output logic                RD_VALID,
    input  logic                RD_READY,
    // completion
    output logic                DONE_VALID,
    output logic [1:0]          DONE_RESP,
    // AW
    output logic [ID_WIDTH-1:0] AWID,
    output logic [31:0]         AWADDR,
    output logic [7:0]          AWLEN,
    output logic [2:0]          AWSIZE,
    output logic [1:0]          AWBURST,
    output logic                AWLOCK,
    output logic [3:0]          AWCACHE,
    output logic [2:0]          AWPROT,
    output logic                AWVALID,
    input  logic                AWREADY,
    // W
    output logic [63:0]         WDATA,
    output logic [7:0]          WSTRB,
    output logic                WLAST,
    output logic                WVALID,
    input  logic                WREADY,
    // B
    input  logic [ID_WIDTH-1:0] BID,
    input  logic [1:0]          BRESP,
    input  logic                BVALID,
    output logic                BREADY,
    // AR
    output logic [ID_WIDTH-1:0] ARID,
    output logic [31:0]         ARADDR,
    output logic [7:0]          ARLEN,
    output logic [2:0]          ARSIZE,
    output logic [1:0]          ARBURST,
    output logic                ARLOCK,
    output logic [3:0]          ARCACHE,
    output logic [2:0]          ARPROT,
    output logic                ARVALID,
    input  logic                ARREADY,
    // R
    input  logic [ID_WIDTH-1:0] RID,
    input  logic [63:0]         RDATA,
    input  logic [1:0]          RRESP,
    input  logic                RLAST,
    input  logic                RVALID,
    output logic                RREADY
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_WRESP = 3'd3;
    localparam logic [2:0] S_RADDR = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic [1:0]  r_resp;

    logic        w_cmd_acc;
    logic [9:0]  w_page_end;
    logic        w_page_err;
    logic        w_last;
    logic        w_wbeat;
    logic        w_rbeat;
    logic [1:0]  w_rstat;

    assign w_cmd_acc  = CMD_VALID && (r_state == S_IDLE);
    // Burst must not run past the 4KB page: last beat index within the page <= 511
    assign w_page_end = {1'b0, CMD_ADDR[11:3]} + {2'b00, CMD_LEN};
    assign w_page_err = (w_page_end > 10'd511);
    assign w_last     = (r_cnt == r_len);
    assign w_wbeat    = (r_state == S_WDATA) && WR_VALID && WREADY;
    assign w_rbeat    = (r_state == S_RDATA) && RVALID && RD_READY;

    // Per-beat read status: subordinate error wins, else RLAST must line up with our count
    always_comb begin
        w_rstat = RESP_OKAY;
        if (RRESP != RESP_OKAY)
            w_rstat = RRESP;
        else if (RLAST != w_last)
            w_rstat = RESP_SLVERR;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_resp  <= RESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc) begin
                        r_addr <= {CMD_ADDR[31:3], 3'b000};
                        r_len  <= CMD_LEN;
                        r_cnt  <= '0;
                        if (w_page_err) begin
                            r_resp  <= RESP_SLVERR;
                            r_state <= S_DONE;
                        end else begin
                            r_resp  <= RESP_OKAY;
                            r_state <= CMD_WRITE ? S_WADDR : S_RADDR;
                        end
                    end
                end
                S_WADDR: if (AWREADY) r_state <= S_WDATA;
                S_WDATA: begin
                    if (w_wbeat) begin
                        if (w_last) r_state <= S_WRESP;
                        else        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_WRESP: begin
                    if (BVALID) begin
                        r_resp  <= BRESP;
                        r_state <= S_DONE;
                    end
                end
                S_RADDR: if (ARREADY) r_state <= S_RDATA;
                S_RDATA: begin
                    if (w_rbeat) begin
                        // First bad status sticks for the whole burst
                        if (r_resp == RESP_OKAY && w_rstat != RESP_OKAY)
                            r_resp <= w_rstat;
                        if (w_last) r_state <= S_DONE;
                        else        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY  = (r_state == S_IDLE);
    assign DONE_VALID = (r_state == S_DONE);
    assign DONE_RESP  = (r_state == S_DONE) ? r_resp : RESP_OKAY;

    assign AWID    = ID_WIDTH'(AXI_ID);
    assign AWADDR  = r_addr;
    assign AWLEN   = r_len;
    assign AWSIZE  = 3'b011;
    assign AWBURST = 2'b01;
    assign AWLOCK  = 1'b0;
    assign AWCACHE = 4'b0000;
    assign AWPROT  = 3'b000;
    assign AWVALID = (r_state == S_WADDR);

    assign WDATA    = WR_DATA;
    assign WSTRB    = WR_STRB;
    assign WLAST    = (r_state == S_WDATA) && w_last;
    assign WVALID   = (r_state == S_WDATA) && WR_VALID;
    assign WR_READY = (r_state == S_WDATA) && WREADY;
    assign BREADY   = (r_state == S_WRESP);

    assign ARID    = ID_WIDTH'(AXI_ID);
    assign ARADDR  = r_addr;
    assign ARLEN   = r_len;
    assign ARSIZE  = 3'b011;
    assign ARBURST = 2'b01;
    assign ARLOCK  = 1'b0;
    assign ARCACHE = 4'b0000;
    assign ARPROT  = 3'b000;
    assign ARVALID = (r_state == S_RADDR);

    assign RD_DATA  = RDATA;
    assign RD_LAST  = (r_state == S_RDATA) && w_last;
    assign RD_VALID = (r_state == S_RDATA) && RVALID;
    assign RREADY   = (r_state == S_RDATA) && RD_READY;

    // Single-ID fabric: response IDs are not checked; low address bits are word-aligned away
    logic w_unused_ok;
    assign w_unused_ok = ^{BID, RID, CMD_ADDR[2:0], (ARB_PRIO != 0)};

endmodule

// File: tb/tb_aha_axi_burst_master.sv
// Bench for aha_axi_burst_master: behavioural AXI memory + stream endpoints, table of
// directed commands, and a hand-written mid-burst reset sequence.
module tb_aha_axi_burst_master;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        CMD_VALID, CMD_READY, CMD_WRITE;
    logic [31:0] CMD_ADDR;
    logic [7:0]  CMD_LEN;
    logic [63:0] WR_DATA;
    logic [7:0]  WR_STRB;
    logic        WR_VALID, WR_READY;
    logic [63:0] RD_DATA;
    logic        RD_LAST, RD_VALID, RD_READY;
    logic        DONE_VALID;
    logic [1:0]  DONE_RESP;
    logic [3:0]  AWID, ARID, BID, RID;
    logic [31:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWLOCK, ARLOCK;
    logic [3:0]  AWCACHE, ARCACHE;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [63:0] WDATA, RDATA;
    logic [7:0]  WSTRB;

    always #5 ACLK = ~ACLK;

    aha_axi_burst_master #(.ID_WIDTH(4), .AXI_ID(0), .ARB_PRIO(0)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .WR_DATA(WR_DATA), .WR_STRB(WR_STRB), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
        .RD_DATA(RD_DATA), .RD_LAST(RD_LAST), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .DONE_VALID(DONE_VALID), .DONE_RESP(DONE_RESP),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  strb;
        logic        stall;
        int          err_beat;   // R beat index returning SLVERR, -1 = none
        int          rlast_mode; // 0 correct, 1 never, 2 on beat 0 only
        logic [1:0]  bresp;
        logic [1:0]  exp_resp;
        logic        exp_axi;    // 0 = 4KB reject, no AXI traffic expected
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int v, input int k);
        return 64'hDEADBEEF_CAFEF00D + (64'(v) << 40) + 64'(k) * 64'h0000_0001_0001_0001;
    endfunction

    // configuration written by the main sequence, read by the environment
    logic       cfg_wr_en, cfg_stall;
    logic [7:0] cfg_len, cfg_strb;
    logic [1:0] cfg_bresp;
    int         cfg_v, cfg_err_beat, cfg_rlast_mode;

    logic [63:0] exp_mem [512];
    logic [63:0] sub_mem [512];

    // environment-owned monitor state
    int          cyc, acc_cyc, done_cyc, done_cnt, axi_cyc;
    int          aw_hs, ar_hs, aw_unstable, w_early, wlast_err, w_beats;
    int          rd_n, last_cnt, last_idx, wb, rb, wr_idx;
    logic [31:0] cap_awaddr, cap_araddr, aw_prev;
    logic [7:0]  cap_awlen, cap_arlen;
    logic [63:0] rd_got [256];
    logic        aw_wait, b_pend, r_act, r_hs, wv_hs, wr_armed;
    logic [8:0]  e_idx;

    // Environment: sample handshakes at posedge, drive new values at negedge
    initial begin
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; BID = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0; RID = 0;
        WR_VALID = 0; WR_DATA = 0; WR_STRB = 0; RD_READY = 0;
        for (int i = 0; i < 512; i++) sub_mem[i] = '0;
        cyc = 0; acc_cyc = 0; done_cyc = 0; done_cnt = 0; axi_cyc = 0;
        aw_hs = 0; ar_hs = 0; aw_unstable = 0; w_early = 0; wlast_err = 0; w_beats = 0;
        rd_n = 0; last_cnt = 0; last_idx = -1; wb = 0; rb = 0; wr_idx = 0;
        cap_awaddr = 0; cap_araddr = 0; aw_prev = 0; cap_awlen = 0; cap_arlen = 0;
        aw_wait = 0; b_pend = 0; r_act = 0; r_hs = 0; wv_hs = 0; wr_armed = 0;
        forever begin
            @(posedge ACLK);
            cyc++;
            if (!ARESETn) begin
                aw_wait = 0; b_pend = 0; r_act = 0; r_hs = 0; wv_hs = 0; wr_armed = 0;
            end else begin
                if (CMD_VALID && CMD_READY) begin
                    acc_cyc = cyc; done_cnt = 0; axi_cyc = 0; aw_hs = 0; ar_hs = 0;
                    aw_unstable = 0; w_early = 0; wlast_err = 0; w_beats = 0;
                    rd_n = 0; last_cnt = 0; last_idx = -1; wr_idx = 0; wr_armed = cfg_wr_en;
                end
                if (DONE_VALID) begin done_cnt++; done_cyc = cyc; end
                if (AWVALID || ARVALID) axi_cyc++;
                if (aw_wait && (!AWVALID || AWADDR != aw_prev)) aw_unstable++;
                aw_wait = AWVALID && !AWREADY;
                aw_prev = AWADDR;
                if (BVALID && BREADY) b_pend = 0;
                if (WVALID && WREADY) begin
                    if (aw_hs == 0) w_early++;
                    if (WLAST !== (wb == int'(cap_awlen))) wlast_err++;
                    e_idx = cap_awaddr[11:3] + 9'(wb);
                    for (int b = 0; b < 8; b++)
                        if (WSTRB[b]) sub_mem[e_idx][8*b +: 8] = WDATA[8*b +: 8];
                    wb++; w_beats++;
                    if (WLAST) b_pend = 1;
                end
                if (AWVALID && AWREADY) begin
                    aw_hs++; cap_awaddr = AWADDR; cap_awlen = AWLEN; wb = 0;
                end
                r_hs = RVALID && RREADY;
                if (r_hs) begin
                    rb++;
                    if (rb > int'(cap_arlen)) r_act = 0;
                end
                if (ARVALID && ARREADY) begin
                    ar_hs++; cap_araddr = ARADDR; cap_arlen = ARLEN; rb = 0; r_act = 1;
                end
                if (RD_VALID && RD_READY) begin
                    if (rd_n < 256) rd_got[rd_n] = RD_DATA;
                    if (RD_LAST) begin last_cnt++; last_idx = rd_n; end
                    rd_n++;
                end
                wv_hs = WR_VALID && WR_READY;
                if (wv_hs) wr_idx++;
            end
            @(negedge ACLK);
            if (!ARESETn) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                RLAST = 0; WR_VALID = 0; RD_READY = 0;
            end else begin
                AWREADY = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                WREADY  = cfg_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                ARREADY = cfg_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                BVALID  = b_pend;
                BRESP   = cfg_bresp;
                if (!r_act)                RVALID = 0;
                else if (RVALID && !r_hs)  RVALID = 1;
                else                       RVALID = cfg_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                e_idx = cap_araddr[11:3] + 9'(rb);
                RDATA = sub_mem[e_idx];
                RRESP = (rb == cfg_err_beat) ? 2'b10 : 2'b00;
                case (cfg_rlast_mode)
                    1:       RLAST = 1'b0;
                    2:       RLAST = (rb == 0);
                    default: RLAST = (rb == int'(cap_arlen));
                endcase
                if (!wr_armed || wr_idx > int'(cfg_len)) WR_VALID = 0;
                else if (WR_VALID && !wv_hs)             WR_VALID = 1;
                else WR_VALID = cfg_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                WR_DATA  = pat(cfg_v, wr_idx);
                WR_STRB  = cfg_strb;
                RD_READY = cfg_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                                input logic [7:0] strb, input logic stall, input int eb,
                                input int rl, input logic [1:0] br, input logic [1:0] er,
                                input logic ax);
        vec_t v;
        v.wr = wr; v.addr = addr; v.len = len; v.strb = strb; v.stall = stall;
        v.err_beat = eb; v.rlast_mode = rl; v.bresp = br; v.exp_resp = er; v.exp_axi = ax;
        return v;
    endfunction

    // Issue one command, wait for completion, check everything. Called at a negedge.
    task automatic run_vec(input vec_t v, input int vi);
        logic        got;
        logic [8:0]  idx;
        logic [63:0] pv;
        int          mism;
        cfg_wr_en = v.wr; cfg_len = v.len; cfg_v = vi; cfg_strb = v.strb; cfg_stall = v.stall;
        cfg_err_beat = v.err_beat; cfg_rlast_mode = v.rlast_mode; cfg_bresp = v.bresp;
        CMD_VALID = 1; CMD_WRITE = v.wr; CMD_ADDR = v.addr; CMD_LEN = v.len;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (CMD_READY) begin got = 1; break; end
            @(negedge ACLK);
        end
        chk($sformatf("v%0d cmd_ready", vi), 64'(got), 64'd1);
        @(negedge ACLK);
        CMD_VALID = 0;
        if (v.wr && v.exp_axi)
            for (int k = 0; k <= int'(v.len); k++) begin
                idx = v.addr[11:3] + 9'(k);
                pv = pat(vi, k);
                for (int b = 0; b < 8; b++)
                    if (v.strb[b]) exp_mem[idx][8*b +: 8] = pv[8*b +: 8];
            end
        got = 0;
        for (int c = 0; c < 4000; c++) begin
            #1;
            if (DONE_VALID) begin got = 1; break; end
            @(negedge ACLK);
        end
        chk($sformatf("v%0d done_seen", vi), 64'(got), 64'd1);
        chk($sformatf("v%0d done_resp", vi), 64'(DONE_RESP), 64'(v.exp_resp));
        @(negedge ACLK); #1;
        chk($sformatf("v%0d idle_after", vi), {62'd0, CMD_READY, DONE_VALID}, 64'b10);
        chk($sformatf("v%0d done_pulses", vi), 64'(done_cnt), 64'd1);
        if (!v.exp_axi) begin
            chk($sformatf("v%0d axi_cycles", vi), 64'(axi_cyc), 64'd0);
            chk($sformatf("v%0d err_latency", vi), 64'(done_cyc - acc_cyc), 64'd1);
        end else if (v.wr) begin
            chk($sformatf("v%0d aw_hs", vi), 64'(aw_hs), 64'd1);
            chk($sformatf("v%0d awaddr", vi), 64'(cap_awaddr), 64'({v.addr[31:3], 3'b000}));
            chk($sformatf("v%0d awlen", vi), 64'(cap_awlen), 64'(v.len));
            chk($sformatf("v%0d w_beats", vi), 64'(w_beats), 64'(int'(v.len) + 1));
            chk($sformatf("v%0d wlast_err", vi), 64'(wlast_err), 64'd0);
            chk($sformatf("v%0d aw_unstable", vi), 64'(aw_unstable), 64'd0);
            chk($sformatf("v%0d w_before_aw", vi), 64'(w_early), 64'd0);
            mism = 0;
            for (int k = 0; k <= int'(v.len); k++) begin
                idx = v.addr[11:3] + 9'(k);
                if (sub_mem[idx] !== exp_mem[idx]) mism++;
            end
            chk($sformatf("v%0d wdata_mism", vi), 64'(mism), 64'd0);
        end else begin
            chk($sformatf("v%0d ar_hs", vi), 64'(ar_hs), 64'd1);
            chk($sformatf("v%0d araddr", vi), 64'(cap_araddr), 64'({v.addr[31:3], 3'b000}));
            chk($sformatf("v%0d arlen", vi), 64'(cap_arlen), 64'(v.len));
            chk($sformatf("v%0d rd_beats", vi), 64'(rd_n), 64'(int'(v.len) + 1));
            chk($sformatf("v%0d rd_last", vi), {32'(last_cnt), 32'(last_idx)},
                {32'd1, 32'(v.len)});
            mism = 0;
            for (int k = 0; k <= int'(v.len); k++) begin
                idx = v.addr[11:3] + 9'(k);
                if (rd_got[k] !== exp_mem[idx]) mism++;
            end
            chk($sformatf("v%0d rdata_mism", vi), 64'(mism), 64'd0);
        end
    endtask

    vec_t tbl [17];

    initial begin
        logic got;
        tbl[0]  = mk(1, 32'h0000_0100, 8'd0,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);
        tbl[1]  = mk(1, 32'h0000_0100, 8'd3,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);
        tbl[2]  = mk(0, 32'h0000_0100, 8'd3,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);
        tbl[3]  = mk(1, 32'h0000_0FF8, 8'd1,   8'hFF, 0, -1, 0, 2'b00, 2'b10, 0);
        tbl[4]  = mk(0, 32'h0000_0FF8, 8'd0,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);
        tbl[5]  = mk(1, 32'h0000_0000, 8'd255, 8'hFF, 1, -1, 0, 2'b00, 2'b00, 1);
        tbl[6]  = mk(0, 32'h0000_0000, 8'd255, 8'hFF, 1, -1, 0, 2'b00, 2'b00, 1);
        tbl[7]  = mk(0, 32'h0000_0200, 8'd3,   8'hFF, 0,  1, 0, 2'b00, 2'b10, 1);
        tbl[8]  = mk(1, 32'h0000_0040, 8'd2,   8'hFF, 0, -1, 0, 2'b11, 2'b11, 1);
        tbl[9]  = mk(0, 32'h0000_0E08, 8'd200, 8'hFF, 0, -1, 0, 2'b00, 2'b10, 0);
        tbl[10] = mk(1, 32'h0000_01F5, 8'd5,   8'h0F, 1, -1, 0, 2'b00, 2'b00, 1);
        tbl[11] = mk(0, 32'h0000_01F0, 8'd5,   8'hFF, 1, -1, 0, 2'b00, 2'b00, 1);
        tbl[12] = mk(0, 32'h0000_0100, 8'd1,   8'hFF, 0, -1, 1, 2'b00, 2'b10, 1);
        tbl[13] = mk(0, 32'h0000_0100, 8'd2,   8'hFF, 0, -1, 2, 2'b00, 2'b10, 1);
        tbl[14] = mk(1, 32'h2000_0FFF, 8'd0,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);
        tbl[15] = mk(0, 32'h0000_0FF8, 8'd0,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);
        tbl[16] = mk(0, 32'h0000_3FF0, 8'd1,   8'hFF, 0, -1, 0, 2'b00, 2'b00, 1);

        for (int i = 0; i < 512; i++) exp_mem[i] = '0;
        cfg_wr_en = 0; cfg_stall = 0; cfg_len = 0; cfg_strb = 8'hFF; cfg_bresp = 0;
        cfg_v = 0; cfg_err_beat = -1; cfg_rlast_mode = 0;
        CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = 0; CMD_LEN = 0;
        ARESETn = 0;

        @(negedge ACLK); #1;
        chk("reset cmd_ready", 64'(CMD_READY), 64'd1);
        chk("reset valids", {58'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY, DONE_VALID}, 64'd0);
        chk("reset done_resp", 64'(DONE_RESP), 64'd0);
        chk("reset axi consts", {49'd0, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT},
            {49'd0, 3'b011, 2'b01, 1'b0, 4'b0000, 3'b000});
        ARESETn = 1;
        @(negedge ACLK); #1;

        for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

        // Mid-burst reset while the fifth write beat is presented
        cfg_wr_en = 1; cfg_len = 8'd9; cfg_v = 20; cfg_strb = 8'hFF; cfg_stall = 0;
        cfg_err_beat = -1; cfg_rlast_mode = 0; cfg_bresp = 0;
        CMD_VALID = 1; CMD_WRITE = 1; CMD_ADDR = 32'h300; CMD_LEN = 8'd9;
        @(negedge ACLK);
        CMD_VALID = 0;
        got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge ACLK); #1;
            if (w_beats >= 4) begin got = 1; break; end
        end
        chk("rst reached beat5", 64'(got), 64'd1);
        chk("rst wvalid before", 64'(WVALID), 64'd1);
        ARESETn = 0;
        #1;
        chk("rst valids low", {57'd0, AWVALID, WVALID, WR_READY, BREADY, ARVALID, RREADY, DONE_VALID},
            64'd0);
        @(negedge ACLK);
        cfg_wr_en = 0;
        ARESETn = 1;
        @(negedge ACLK); #1;
        chk("rst cmd_ready after", 64'(CMD_READY), 64'd1);
        repeat (5) @(negedge ACLK);
        #1;
        chk("rst no done", 64'(done_cnt), 64'd0);

        run_vec(tbl[2], 21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
